// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
//
// Flag consumer sitting between instruction decode and the fetch address port.
// It accepts branch requests from the decoder and samples the C/Z/V/S flags one
// cycle after the request is accepted. It then evaluates a 4-bit condition code
// and updates the program counter. Without a branch, pc advances on pc_inc.
//
// Optional feature macro: CALL_STACK_EN
//   defined   - call/return stack of STACK_DEPTH entries, with a sticky stk_err
//               flag for overflow and underflow.
//   undefined - call behaves as a plain conditional jump, ret is never taken,
//               stk_err is tied low and there is no stack storage.
//
// Parameters
//   PC_W         program counter width
//   STACK_DEPTH  return-address entries (power of 2, >= 2)
//
// Ports
//   clk                            clock, rising edge
//   reset                          asynchronous, active-low reset
//   flag_c/flag_z/flag_v/flag_s    flags from the flag register
//   pc_inc                         sequential advance request (honoured in IDLE only)
//   br_valid / br_ready            branch request handshake
//   br_cond, br_target             condition code and jump target
//   br_call, br_ret                call / return qualifiers
//   pc                             program counter
//   pc_load                        1-cycle pulse when pc was loaded non-sequentially
//   taken                          result of the last evaluation, held until next COMMIT
//   stk_err                        sticky stack overflow/underflow
//
// Handshake: a request transfers on a rising clk edge where br_valid and
// br_ready are both high. br_ready is high only in IDLE and does not depend
// on br_valid. The decoder may change or drop br_valid at any time. The
// request fields are only looked at on the transfer edge.
//
// FSM: IDLE -> EVAL -> COMMIT -> IDLE. The current state is visible as the
// internal signal 'state' of type state_t.
// -----------------------------------------------------------------------------
module branch_unit #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flag_c,
    input  logic            flag_z,
    input  logic            flag_v,
    input  logic            flag_s,
    input  logic            pc_inc,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [3:0]      br_cond,
    input  logic [PC_W-1:0] br_target,
    input  logic            br_call,
    input  logic            br_ret,
    output logic [PC_W-1:0] pc,
    output logic            pc_load,
    output logic            taken,
    output logic            stk_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic            handshake;
    logic [3:0]      cond_q;
    logic [PC_W-1:0] target_q;
    logic            call_q;
    logic            ret_q;
    logic            cond_res;

    // Decision made in COMMIT: whether pc is loaded, and from where.
    logic            commit_taken;
    logic [PC_W-1:0] commit_dest;

    logic [PC_W-1:0] pc_plus1;

    assign pc_plus1  = pc + PC_W'(1);
    assign handshake = br_valid & br_ready;

    function automatic logic eval_cond(input logic [3:0] cc,
                                       input logic c, input logic z,
                                       input logic v, input logic s);
        logic r;
        case (cc)
            4'h0:    r = 1'b1;
            4'h1:    r = z;
            4'h2:    r = ~z;
            4'h3:    r = c;
            4'h4:    r = ~c;
            4'h5:    r = s;
            4'h6:    r = ~s;
            4'h7:    r = v;
            4'h8:    r = ~v;
            4'h9:    r = (s == v);
            4'hA:    r = (s != v);
            4'hB:    r = ~z & (s == v);
            4'hC:    r = z | (s != v);
            4'hD:    r = c & ~z;
            4'hE:    r = ~c | z;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (br_valid) state_next = ST_EVAL;
            ST_EVAL:   state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        br_ready = (state == ST_IDLE);
    end

`ifdef CALL_STACK_EN
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [PC_W-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-1:0] sp;        // number of valid entries
    logic            stk_full;
    logic            stk_empty;
    logic            push;
    logic            pop;
    logic            stk_fault;

    assign stk_full  = (sp == SP_W'(STACK_DEPTH));
    assign stk_empty = (sp == '0);

    // A ret that finds the stack empty is demoted to not-taken.
    // A call that finds the stack full still jumps but loses its return address.
    always_comb begin
        commit_taken = cond_res;
        commit_dest  = target_q;
        push         = 1'b0;
        pop          = 1'b0;
        stk_fault    = 1'b0;
        if (ret_q) begin
            if (cond_res) begin
                if (stk_empty) begin
                    commit_taken = 1'b0;
                    stk_fault    = 1'b1;
                end else begin
                    pop         = 1'b1;
                    commit_dest = stack_mem[IDX_W'(sp - SP_W'(1))];
                end
            end
        end else if (call_q && cond_res) begin
            if (stk_full) begin
                stk_fault = 1'b1;
            end else begin
                push = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_COMMIT && push) begin
            stack_mem[IDX_W'(sp)] <= pc_plus1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp      <= '0;
            stk_err <= 1'b0;
        end else if (state == ST_COMMIT) begin
            if (push) begin
                sp <= sp + SP_W'(1);
            end else if (pop) begin
                sp <= sp - SP_W'(1);
            end
            if (stk_fault) begin
                stk_err <= 1'b1;
            end
        end
    end
`else
    // Without a stack, a call is an ordinary conditional jump and a ret is never taken.
    always_comb begin
        commit_taken = cond_res & ~ret_q;
        commit_dest  = target_q;
    end

    assign stk_err = 1'b0;

    // The call qualifier carries no meaning in this build.
    logic unused_call;
    assign unused_call = &{1'b0, br_call, call_q};
`endif

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= '0;
            pc_load  <= 1'b0;
            taken    <= 1'b0;
            cond_res <= 1'b0;
            cond_q   <= '0;
            target_q <= '0;
            call_q   <= 1'b0;
            ret_q    <= 1'b0;
        end else begin
            pc_load <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A branch handshake takes priority and drops pc_inc.
                    if (handshake) begin
                        cond_q   <= br_cond;
                        target_q <= br_target;
                        call_q   <= br_call & ~br_ret;
                        ret_q    <= br_ret;
                    end else if (pc_inc) begin
                        pc <= pc_plus1;
                    end
                end
                ST_EVAL: begin
                    // The flags are sampled here, one cycle after the handshake.
                    // By then the preceding ALU flag write has landed.
                    cond_res <= eval_cond(cond_q, flag_c, flag_z, flag_v, flag_s);
                end
                ST_COMMIT: begin
                    taken <= commit_taken;
                    if (commit_taken) begin
                        pc      <= commit_dest;
                        pc_load <= 1'b1;
                    end else begin
                        pc <= pc_plus1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
